// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage in front of a combinational instruction memory.
// It owns the PC and drives imem_addr. The memory word is registered into IF/ID
// with a valid bit. Start-up, stall, redirect and end-of-program halt are all
// handled by one IDLE/RUN/HALTED machine.
// Optional build macro FETCH_PERF_CNT_EN adds two saturating 16-bit counters:
// fetch_count and stall_count.
//
// Handshake note: there is no valid/ready pair here. stall is a hold request
// that applies on the edge where it is sampled. redirect_valid is a one-cycle
// command that also applies on the edge where it is sampled. redirect_valid
// wins over stall, and reset wins over both.
module instruction_fetch #(
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned END_ADDR = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc,
   output logic [ADDR_W-1:0] ifid_pc_plus1,
   output logic              ifid_valid,
   output logic              halted,
   output logic [1:0]        state_dbg
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]       fetch_count,
   output logic [15:0]       stall_count
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] RESET_A = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);
   localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

   state_t            state;
   logic [ADDR_W-1:0] pc;

   assign imem_addr = pc;
   assign state_dbg = state;

   // FSM, PC and IF/ID register. A redirect squashes the wrong-path word but
   // keeps ifid_pc and ifid_pc_plus1.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pc            <= RESET_A;
         ifid_instr    <= '0;
         ifid_pc       <= '0;
         ifid_pc_plus1 <= '0;
         ifid_valid    <= 1'b0;
         halted        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ifid_valid <= 1'b0;
               if (redirect_valid) begin
                  pc <= redirect_pc;
               end else if (start) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (redirect_valid) begin
                  pc         <= redirect_pc;
                  ifid_valid <= 1'b0;
                  ifid_instr <= '0;
               end else if (!stall) begin
                  ifid_instr    <= imem_data;
                  ifid_pc       <= pc;
                  ifid_pc_plus1 <= pc + ONE_A;
                  ifid_valid    <= 1'b1;
                  pc            <= pc + ONE_A;
                  // Halt only on exact equality, so a redirect past the end
                  // runs until it wraps back round to END_ADDR.
                  if (pc == END_A) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end
               end
            end
            HALTED: begin
               if (redirect_valid) begin
                  state      <= RUN;
                  halted     <= 1'b0;
                  pc         <= redirect_pc;
                  ifid_valid <= 1'b0;
                  ifid_instr <= '0;
               end else if (!stall) begin
                  ifid_valid <= 1'b0;
                  ifid_instr <= '0;
               end
            end
            default: begin
               state  <= IDLE;
               halted <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Saturating performance counters: useful fetches and stalled RUN cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else if (state == RUN && !redirect_valid) begin
         if (!stall && fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
         end
         if (stall && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed test of the fetch stage. A behavioural program
// model is checked against the DUT on every cycle. Hand-computed literals pin
// the key points of each scenario.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [5:0]  redirect_pc = '0;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;
   logic [31:0] ifid_instr;
   logic [5:0]  ifid_pc;
   logic [5:0]  ifid_pc_plus1;
   logic        ifid_valid;
   logic        halted;
   logic [1:0]  state_dbg;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count;
   logic [15:0] stall_count;
`endif

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- program memory ----------------
   logic [31:0] prog [64];
   initial begin
      for (int i = 0; i < 64; i++) prog[i] = 32'hA000_0000 | i;
      prog[0] = 32'h0022_1820;
      prog[9] = 32'h8D6C_0020;
   end
   assign imem_data = prog[imem_addr];

   instruction_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .ifid_instr     (ifid_instr),
      .ifid_pc        (ifid_pc),
      .ifid_pc_plus1  (ifid_pc_plus1),
      .ifid_valid     (ifid_valid),
      .halted         (halted),
      .state_dbg      (state_dbg)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count    (fetch_count),
      .stall_count    (stall_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%08h want 0x%08h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // running/stopped describe the program's status, not the DUT's encoding.
   int          m_pc;
   bit          m_started, m_stopped;
   logic [31:0] m_instr;
   int          m_ipc, m_ipc1;
   bit          m_valid;
   int          m_fetches, m_stalls;
   bit          armed = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_pc = 0; m_started = 0; m_stopped = 0;
         m_instr = 0; m_ipc = 0; m_ipc1 = 0; m_valid = 0;
         m_fetches = 0; m_stalls = 0;
         armed = 1;
      end else if (!m_started && !m_stopped) begin
         m_valid = 0;
         if (redirect_valid) m_pc = int'(redirect_pc);
         else if (start) m_started = 1;
      end else if (redirect_valid) begin
         m_pc = int'(redirect_pc);
         m_valid = 0; m_instr = 0;
         m_started = 1; m_stopped = 0;
      end else if (stall) begin
         if (!m_stopped && m_stalls < 65535) m_stalls++;
      end else if (m_stopped) begin
         m_valid = 0; m_instr = 0;
      end else begin
         m_instr = prog[m_pc];
         m_ipc   = m_pc;
         m_ipc1  = (m_pc + 1) % 64;
         m_valid = 1;
         if (m_fetches < 65535) m_fetches++;
         if (m_pc == 9) begin
            m_stopped = 1; m_started = 0;
         end
         m_pc = (m_pc + 1) % 64;
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (armed) begin
         chk("imem_addr", 32'(imem_addr), 32'(m_pc));
         chk("ifid_instr", ifid_instr, m_instr);
         chk("ifid_pc", 32'(ifid_pc), 32'(m_ipc));
         chk("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(m_ipc1));
         chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
         chk("halted", 32'(halted), 32'(m_stopped));
`ifdef FETCH_PERF_CNT_EN
         chk("fetch_count", 32'(fetch_count), 32'(m_fetches));
         chk("stall_count", 32'(stall_count), 32'(m_stalls));
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_redirect(input logic [5:0] target, input logic with_stall);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      stall          = with_stall;
      cyc(1);
      redirect_valid = 1'b0;
      stall          = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      reset = 1'b1;
      cyc(2);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_valid", 32'(ifid_valid), 32'd0);
      chk("rst_instr", ifid_instr, 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      reset = 1'b0;
      cyc(2);
      chk("idle_hold_addr", 32'(imem_addr), 32'd0);

      // Start: the first RUN cycle presents address 0 and the next edge latches it.
      start = 1'b1; cyc(1); start = 1'b0;
      chk("run_first_addr", 32'(imem_addr), 32'd0);
      chk("run_first_valid", 32'(ifid_valid), 32'd0);
      cyc(1);
      chk("w0_instr", ifid_instr, 32'h0022_1820);
      chk("w0_pc", 32'(ifid_pc), 32'd0);
      chk("w0_pc1", 32'(ifid_pc_plus1), 32'd1);
      chk("w0_valid", 32'(ifid_valid), 32'd1);
      chk("w0_addr", 32'(imem_addr), 32'd1);
      cyc(2);

      // Stall held for three cycles at pc=3.
      stall = 1'b1; cyc(3);
      chk("stall_addr", 32'(imem_addr), 32'd3);
      chk("stall_ifid_pc", 32'(ifid_pc), 32'd2);
      chk("stall_valid", 32'(ifid_valid), 32'd1);
      stall = 1'b0; cyc(1);
      chk("resume_ifid_pc", 32'(ifid_pc), 32'd3);

      // A redirect together with a stall at pc=4: the redirect wins.
      do_redirect(6'd7, 1'b1);
      chk("redir_addr", 32'(imem_addr), 32'd7);
      chk("redir_valid", 32'(ifid_valid), 32'd0);
      chk("redir_instr", ifid_instr, 32'd0);
      chk("redir_hold_pc", 32'(ifid_pc), 32'd3);
      cyc(1);
      chk("redir_ifid_pc", 32'(ifid_pc), 32'd7);
      chk("redir_valid1", 32'(ifid_valid), 32'd1);

      // Run on to the end address and halt.
      cyc(2);
      chk("end_instr", ifid_instr, 32'h8D6C_0020);
      chk("end_pc", 32'(ifid_pc), 32'd9);
      chk("end_halted", 32'(halted), 32'd1);
      cyc(1);
      chk("halt_valid", 32'(ifid_valid), 32'd0);
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(3);
      chk("halt_addr", 32'(imem_addr), 32'd10);
      chk("halt_still", 32'(halted), 32'd1);

      // Redirect out of HALTED to 63, wrap to 0, stall at 9, then halt again.
      do_redirect(6'd63, 1'b0);
      chk("wrap_unhalt", 32'(halted), 32'd0);
      cyc(1);
      chk("w63_pc", 32'(ifid_pc), 32'd63);
      chk("w63_pc1", 32'(ifid_pc_plus1), 32'd0);
      chk("w63_addr", 32'(imem_addr), 32'd0);
      cyc(9);
      chk("pre_end_addr", 32'(imem_addr), 32'd9);
      stall = 1'b1; cyc(2);
      chk("stall_at_end_halted", 32'(halted), 32'd0);
      chk("stall_at_end_addr", 32'(imem_addr), 32'd9);
      stall = 1'b0; cyc(1);
      chk("wrap_halted", 32'(halted), 32'd1);
      chk("wrap_end_pc", 32'(ifid_pc), 32'd9);

      // A stall in HALTED keeps the last valid word.
      stall = 1'b1; cyc(1);
      chk("halt_stall_valid", 32'(ifid_valid), 32'd1);
      stall = 1'b0; cyc(1);

      // Restart, then assert reset together with a redirect in mid-run.
      do_redirect(6'd2, 1'b0);
      cyc(2);
      reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 6'd5;
      cyc(1);
      reset = 1'b0; redirect_valid = 1'b0;
      chk("mid_rst_addr", 32'(imem_addr), 32'd0);
      chk("mid_rst_valid", 32'(ifid_valid), 32'd0);
      chk("mid_rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("mid_rst_fcnt", 32'(fetch_count), 32'd0);
      chk("mid_rst_scnt", 32'(stall_count), 32'd0);
`endif
      cyc(2);
      chk("post_rst_idle_addr", 32'(imem_addr), 32'd0);

      // A redirect in IDLE loads the PC without starting; then start from there.
      do_redirect(6'd5, 1'b0);
      chk("idle_redir_addr", 32'(imem_addr), 32'd5);
      chk("idle_redir_valid", 32'(ifid_valid), 32'd0);
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(1);
      chk("idle_redir_fetch_pc", 32'(ifid_pc), 32'd5);
      chk("idle_redir_fetch_instr", ifid_instr, 32'hA000_0005);
      cyc(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
